// File: rtl/tx_burst_ctrl.sv
// Burst sequencer in front of TX_path_top: preamble, then byte payload split into
// 2-bit {I,Q} symbols MSB pair first, then a guard gap before the next start.
module tx_burst_ctrl #(
    parameter int PREAMBLE_SYMS = 32,
    parameter int GAP_CYCLES    = 16,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [1:0]           out_data,
    input  logic                 out_ready
);

    localparam int PW = $clog2(PREAMBLE_SYMS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GAP} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        pre_cnt_q, pre_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [LEN_WIDTH-1:0] bytes_left_q, bytes_left_d;
    logic [7:0]           buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [7:0]           sh_q, sh_d;
    logic                 sh_full_q, sh_full_d;
    logic [1:0]           sym_idx_q, sym_idx_d;
    logic                 in_ready_q, in_ready_d;
    logic                 underrun_q, underrun_d;
    logic                 done_q, done_d;

    logic start_acc, start_zero, in_xfer, sh_drain, pay_done, pre_last, gap_last;

    assign start_acc  = (state_q == S_IDLE) && start && (cfg_len != '0);
    assign start_zero = (state_q == S_IDLE) && start && (cfg_len == '0);
    assign in_xfer    = in_valid && in_ready_q;
    assign pre_last   = (pre_cnt_q == PW'(PREAMBLE_SYMS - 1));
    assign gap_last   = (gap_cnt_q == GW'(GAP_CYCLES - 1));
    assign sh_drain   = (state_q == S_PAY) && sh_full_q && out_ready && (sym_idx_q == 2'd3);
    // Nothing left upstream or in the prefetch slot: this drain ends the payload.
    assign pay_done   = sh_drain && (bytes_left_q == '0) && !buf_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pre_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            bytes_left_q <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            sh_q         <= '0;
            sh_full_q    <= 1'b0;
            sym_idx_q    <= '0;
            in_ready_q   <= 1'b0;
            underrun_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            bytes_left_q <= bytes_left_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            sh_q         <= sh_d;
            sh_full_q    <= sh_full_d;
            sym_idx_q    <= sym_idx_d;
            in_ready_q   <= in_ready_d;
            underrun_q   <= underrun_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_acc) state_d = S_PRE;
            S_PRE:   if (out_ready && pre_last) state_d = S_PAY;
            S_PAY:   if (pay_done) state_d = S_GAP;
            S_GAP:   if (gap_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pre_cnt_d    = '0;
        gap_cnt_d    = '0;
        bytes_left_d = bytes_left_q;
        buf_d        = buf_q;
        buf_full_d   = 1'b0;
        sh_d         = sh_q;
        sh_full_d    = 1'b0;
        sym_idx_d    = '0;
        underrun_d   = underrun_q;
        done_d       = start_zero || ((state_q == S_GAP) && gap_last);

        if (state_q == S_IDLE && start) begin
            underrun_d   = 1'b0;
            bytes_left_d = cfg_len;
        end
        if (state_q == S_PRE)
            pre_cnt_d = out_ready ? pre_cnt_q + PW'(1) : pre_cnt_q;
        if (state_q == S_GAP)
            gap_cnt_d = gap_cnt_q + GW'(1);

        if (state_q == S_PAY) begin
            buf_full_d = buf_full_q;
            sh_full_d  = sh_full_q;
            sym_idx_d  = sym_idx_q;
            if (in_xfer && bytes_left_q != '0)
                bytes_left_d = bytes_left_q - LEN_WIDTH'(1);
            if (sh_full_q && out_ready) begin
                sym_idx_d = sym_idx_q + 2'd1;
                if (sym_idx_q == 2'd3)
                    sh_full_d = 1'b0;
            end
            // The shifter is refilled from the prefetch slot first, else straight from the stream.
            if (!sh_full_q || sh_drain) begin
                if (buf_full_q) begin
                    sh_d       = buf_q;
                    sh_full_d  = 1'b1;
                    sym_idx_d  = '0;
                    buf_full_d = 1'b0;
                    if (in_xfer) begin
                        buf_d      = in_data;
                        buf_full_d = 1'b1;
                    end
                end else if (in_xfer) begin
                    sh_d      = in_data;
                    sh_full_d = 1'b1;
                    sym_idx_d = '0;
                end
            end else if (in_xfer) begin
                buf_d      = in_data;
                buf_full_d = 1'b1;
            end
            if (!sh_full_q && !buf_full_q && bytes_left_q != '0 && !in_xfer)
                underrun_d = 1'b1;
        end
    end

    // in_ready is a flop, so out_ready only reaches it through the D input.
    assign in_ready_d = (state_d == S_PAY) && !buf_full_d && (bytes_left_d != '0);

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = done_q;
        underrun  = underrun_q;
        in_ready  = in_ready_q;
        out_valid = 1'b0;
        out_data  = 2'b00;
        if (state_q == S_PRE) begin
            out_valid = 1'b1;
            out_data  = pre_cnt_q[0] ? 2'b00 : 2'b11;
        end else if (state_q == S_PAY && sh_full_q) begin
            out_valid = 1'b1;
            case (sym_idx_q)
                2'd0:    out_data = sh_q[7:6];
                2'd1:    out_data = sh_q[5:4];
                2'd2:    out_data = sh_q[3:2];
                default: out_data = sh_q[1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// Randomised bench for tx_burst_ctrl: a queue-based model predicts the symbol stream,
// gap length, done/busy behaviour and underrun for each burst.
module tb_tx_burst_ctrl;

    localparam int PRE = 4;
    localparam int GAP = 5;
    localparam int LW  = 4;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [LW-1:0] cfg_len;
    logic          busy, done, underrun;
    logic          in_valid, in_ready;
    logic [7:0]    in_data;
    logic          out_valid, out_ready;
    logic [1:0]    out_data;

    int checks = 0;
    int errors = 0;
    int src_q[$];
    int exp_q[$];
    int stall = 0;

    always #5 clk = ~clk;

    tx_burst_ctrl #(.PREAMBLE_SYMS(PRE), .GAP_CYCLES(GAP), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .busy(busy), .done(done), .underrun(underrun),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int or_mode, input int iv_mode);
        in_valid = (src_q.size() > 0) && (stall == 0) && (iv_mode != 2 || ($urandom % 4) != 0);
        in_data  = (src_q.size() > 0) ? 8'(src_q[0]) : 8'($urandom);
        if (stall > 0) stall--;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom % 2);
        endcase
    endtask

    // Caller may preload src_q; the rest of the burst is random bytes.
    task automatic run_burst(input int len, input int or_mode, input int iv_mode, input int exp_ur);
        int cyc = 0, last_cyc = 0, taken = 0, nsym = 0, rdy = 0;
        int ov_idle = 0, unstable = 0, pay_gap = 0;
        bit fin = 0, hold = 0, in_fire, out_fire;
        logic [1:0] held = 2'b00;
        while (src_q.size() < len) src_q.push_back(int'($urandom % 256));
        exp_q.delete();
        for (int p = 0; p < PRE; p++) exp_q.push_back((p % 2 == 0) ? 3 : 0);
        for (int b = 0; b < len; b++)
            for (int k = 0; k < 4; k++) exp_q.push_back((src_q[b] >> (6 - 2 * k)) & 3);
        stall = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_len = LW'(len); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_len = LW'($urandom);
        drive(or_mode, iv_mode);
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            if (out_valid && !busy) ov_idle++;
            if (hold && (!out_valid || out_data != held)) unstable++;
            hold = out_valid && !out_ready;
            held = out_data;
            out_fire = out_valid && out_ready;
            in_fire  = in_valid && in_ready;
            if (in_ready) rdy++;
            if (nsym > PRE && exp_q.size() > 0 && !out_valid) pay_gap++;
            if (out_fire) begin
                if (exp_q.size() == 0) check_eq("extra_sym", int'(out_data), -1);
                else check_eq("sym", int'(out_data), exp_q.pop_front());
                nsym++;
                last_cyc = cyc;
            end
            if (done) begin
                fin = 1;
                check_eq("busy_at_done", int'(busy), 0);
                check_eq("gap_len", cyc - last_cyc - 1, GAP);
                if (exp_ur >= 0) check_eq("underrun", int'(underrun), exp_ur);
            end
            @(posedge clk); #1;
            if (in_fire) begin
                void'(src_q.pop_front());
                taken++;
                if (iv_mode == 1 && taken == 1) stall = 8;
            end
            start   = (cyc == 3);
            cfg_len = (cyc == 3) ? LW'(len + 7) : LW'($urandom);
            drive(or_mode, iv_mode);
            cyc++;
        end
        if (!fin) check_eq("done_timeout", 0, 1);
        @(negedge clk);
        check_eq("done_pulse", int'(done), 0);
        if (exp_ur >= 0) check_eq("underrun_sticky", int'(underrun), exp_ur);
        check_eq("syms_left", exp_q.size(), 0);
        check_eq("bytes_taken", taken, len);
        check_eq("ov_idle", ov_idle, 0);
        check_eq("stable", unstable, 0);
        if (or_mode == 0 && iv_mode == 0) begin
            check_eq("pay_gap", pay_gap, 0);
            check_eq("ready_cycles", rdy, len);
        end
        in_valid = 1'b0;
        src_q.delete();
        $display("burst len=%0d or_mode=%0d iv_mode=%0d syms=%0d underrun=%0d", len, or_mode, iv_mode, nsym, underrun);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_underrun", int'(underrun), 0);
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_data", int'(out_data), 0);
        @(posedge clk); #1 rst = 1'b0;

        src_q.push_back(8'hB4);
        run_burst(1, 0, 0, 0);
        src_q.push_back(8'hFF); src_q.push_back(8'h00);
        run_burst(2, 0, 0, 0);
        src_q.push_back(8'hB4);
        run_burst(1, 1, 0, 0);
        run_burst(3, 0, 1, 1);
        run_burst(2, 0, 0, 0);
        run_burst(15, 0, 0, 0);

        @(posedge clk); #1 start = 1'b1; cfg_len = '0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check_eq("len0_done", int'(done), 1);
        check_eq("len0_busy", int'(busy), 0);
        check_eq("len0_out_valid", int'(out_valid), 0);
        @(negedge clk);
        check_eq("len0_done_pulse", int'(done), 0);
        check_eq("len0_busy2", int'(busy), 0);

        for (int b = 0; b < 4; b++) src_q.push_back(int'($urandom % 256));
        @(posedge clk); #1 start = 1'b1; cfg_len = LW'(4);
        @(posedge clk); #1 start = 1'b0;
        drive(0, 0);
        n = 0;
        for (int c = 0; c < 200 && n < PRE + 3; c++) begin
            bit fi;
            @(negedge clk);
            if (out_valid && out_ready) n++;
            fi = in_valid && in_ready;
            @(posedge clk); #1;
            if (fi) void'(src_q.pop_front());
            drive(0, 0);
        end
        check_eq("pre_reset_syms", n, PRE + 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; src_q.delete();
        @(negedge clk);
        check_eq("mid_rst_out_valid", int'(out_valid), 0);
        check_eq("mid_rst_in_ready", int'(in_ready), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        run_burst(3, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            int im;
            im = int'($urandom % 3);
            if (im == 1) im = 0;
            run_burst(int'($urandom_range(1, 15)), int'($urandom % 3), im, (im == 0) ? 0 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
